central_fuzz_gen: RTL
=====================

# central_fuzz_gen

Parametrised central fuzz traffic generator. It issues bursts of TRAFFIC_N single Wishbone transactions into the address window of one of IP_NUM target IPs, using one of three fuzz modes: LFSR random, corner-case sweep, or write/read-back compare. It sits between the central fuzz control and the Wishbone master port. It adds features the previous generation lacked: a per-IP address window, a reproducible seed, an ack timeout, and read-back mismatch counting.

## Interface
- ADDR_WIDTH, 32, Wishbone address width
- DATA_WIDTH, 32, Wishbone data width; legal values 8, 16, 32
- IP_NUM, 4, number of target IPs
- IP_SELECTOR_WIDTH, 2, width of ip_selector; must satisfy 2^IP_SELECTOR_WIDTH >= IP_NUM
- TRAFFIC_N, 2, transactions per burst; must be >= 1
- IP_WINDOW_BITS, 12, byte-offset bits per IP window
- TIMEOUT_CYCLES, 16, maximum cycles to wait for an ack

Ports:
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- start  in  1  begins a burst when accepted
- mode_selector  in  2  0 idle, 1 random, 2 corner, 3 write/read-back
- ip_selector  in  IP_SELECTOR_WIDTH  target IP
- seed  in  32  LFSR seed, loaded when start is accepted
- busy  out  1  high while a burst is in progress
- done  out  1  one-cycle pulse at the end of a burst
- timeout  out  1  sticky flag; set when any transaction times out during the burst
- mismatch_cnt  out  16  saturating count of read-back mismatches
- last_rdata  out  DATA_WIDTH  data from the most recent read ack
- corner_case_payload  out  DATA_WIDTH  current corner-case pattern
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe, write enable
- wbm_adr_o  out  ADDR_WIDTH  address
- wbm_dat_o  out  DATA_WIDTH  write data
- wbm_sel_o  out  DATA_WIDTH/8  byte selects
- wbm_cti_o  out  3  cycle type identifier
- wbm_bte_o  out  2  burst type extension
- wbm_dat_i  in  DATA_WIDTH  read data
- wbm_ack_i  in  1  acknowledge

## Operation
- FSM states: IDLE, REQ, RB_REQ, NEXT, DONE.
- Start acceptance:
  - start is accepted only in IDLE with mode_selector != 0.
  - start in mode 0, or while busy, is ignored.
- On accept:
  - latch mode and ip_selector;
  - load the LFSR with seed; a seed of 0 is replaced by 32'hACE10001;
  - clear timeout and mismatch_cnt, clear the corner index and the transaction count;
  - go to REQ.
- LFSR: 32-bit Galois, taps 32'h80200003. It advances once per transaction, in NEXT.
- Address: (ip_selector << IP_WINDOW_BITS) | word-aligned offset. The offset is {lfsr[IP_WINDOW_BITS-1:2], 2'b00}, zero-extended to ADDR_WIDTH.
- Mode 1 (random): wbm_we_o = lfsr[31]; wbm_dat_o = lfsr[DATA_WIDTH-1:0].
- Mode 2 (corner):
  - Writes only.
  - The 2-bit corner index cycles through these patterns, truncated to DATA_WIDTH: 0x00000000, 0xFFFFFFFF, 0xAAAAAAAA, 0x55555555.
  - Offset is 0 for even indices and the maximum word offset (2^IP_WINDOW_BITS - 4) for odd indices.
  - corner_case_payload = current pattern in every mode. It holds 0 after reset.
- Mode 3 (read-back):
  - Each transaction is a random-data write (REQ), then a read of the same address (RB_REQ).
  - On the read ack, wbm_dat_i != written data increments mismatch_cnt, saturating at 16'hFFFF.
- Bus cycles are classic single transfers: wbm_sel_o all ones, wbm_cti_o 3'b000, wbm_bte_o 2'b00.
- Ack handling:
  - In REQ/RB_REQ, wbm_cyc_o and wbm_stb_o are held until wbm_ack_i. Address, data and we stay stable for the whole request.
  - A read ack captures last_rdata.
  - Acks outside a request are ignored.
- Timeout:
  - A wait counter starts at 0 when the request is asserted.
  - When the counter reaches TIMEOUT_CYCLES-1 without an ack, cyc/stb drop, timeout is set, and the transaction counts as complete. In mode 3 the read-back is skipped and no mismatch is counted.
- NEXT:
  - increment the transaction count, advance the LFSR and the corner index;
  - go to REQ if count < TRAFFIC_N, else go to DONE.
- DONE: done = 1 for one cycle, then IDLE.

## Timing
- Reset values: all outputs 0 (except the constant wbm_sel_o all ones); LFSR = 32'hACE10001; state IDLE.
- start is sampled at edge 0. busy, wbm_cyc_o and wbm_stb_o are high from cycle 1.
- Ack sampled at edge k: cyc/stb are low in cycle k+1 (NEXT), and the next request starts in cycle k+2. In mode 3 the read request starts in cycle k+1.
- After the last transaction's NEXT, done is high for one cycle and busy falls together with done.
- Minimum burst length for TRAFFIC_N=2 with zero-wait acks (modes 1/2) is 6 cycles from start to done.
- rst asserted mid-burst: cyc/stb are low and all state is cleared at the next edge. No partial done pulse is generated.
- An ack in the same cycle as the timeout threshold counts as an ack; no timeout is recorded.

## Test plan
- Mode 2, ip_selector=1, IP_WINDOW_BITS=12, TRAFFIC_N=4, immediate acks -> four writes:
  - 0x1000 / 0x00000000
  - 0x1FFC / 0xFFFFFFFF
  - 0x1000 / 0xAAAAAAAA
  - 0x1FFC / 0x55555555
  - then one done pulse.
- Mode 1 with seed 0 and seed 32'hACE10001 -> identical address/data/we sequences; each sequence matches a reference Galois LFSR model.
- Mode 3 with a slave returning written data XOR 1 on every read, TRAFFIC_N=2 -> 2 writes and 2 reads to paired addresses; mismatch_cnt=2.
- Slave never acks, TIMEOUT_CYCLES=16, TRAFFIC_N=2 -> each stb lasts exactly 16 cycles; timeout=1; done asserted; no read issued in mode 3.
- rst asserted at cycle 3 of a burst -> cyc/stb/busy are 0 at the next edge; no done pulse; a subsequent start runs normally.
- start in mode 0, and start pulsed while busy -> no bus activity and no change to the burst in progress.

Source files
------------

// File: rtl/central_fuzz_gen.sv
// Central fuzz traffic generator: bursts of single Wishbone transfers into one IP window,
// driven by an LFSR, a corner-case sweep, or a write/read-back compare.
module central_fuzz_gen #(
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned IP_NUM            = 4,
  parameter int unsigned IP_SELECTOR_WIDTH = 2,
  parameter int unsigned TRAFFIC_N         = 2,
  parameter int unsigned IP_WINDOW_BITS    = 12,
  parameter int unsigned TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode_selector,
  input  logic [IP_SELECTOR_WIDTH-1:0] ip_selector,
  input  logic [31:0]                  seed,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [15:0]                  mismatch_cnt,
  output logic [DATA_WIDTH-1:0]        last_rdata,
  output logic [DATA_WIDTH-1:0]        corner_case_payload,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic                         wbm_we_o,
  output logic [ADDR_WIDTH-1:0]        wbm_adr_o,
  output logic [DATA_WIDTH-1:0]        wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0]      wbm_sel_o,
  output logic [2:0]                   wbm_cti_o,
  output logic [1:0]                   wbm_bte_o,
  input  logic [DATA_WIDTH-1:0]        wbm_dat_i,
  input  logic                         wbm_ack_i
);

  localparam int unsigned CNT_W  = $clog2(TRAFFIC_N + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SEL_W  = DATA_WIDTH / 8;

  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam logic [31:0] LFSR_DEFAULT = 32'hACE10001;
  localparam logic [ADDR_WIDTH-1:0] MAX_OFS = ADDR_WIDTH'((2 ** IP_WINDOW_BITS) - 4);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_RB_REQ = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  if ((IP_NUM > (2 ** IP_SELECTOR_WIDTH)) || (TRAFFIC_N < 1) ||
      ((DATA_WIDTH != 8) && (DATA_WIDTH != 16) && (DATA_WIDTH != 32))) begin : g_bad_params
    $error("central_fuzz_gen: illegal parameter combination");
  end

  function automatic logic [DATA_WIDTH-1:0] corner_pat(input logic [1:0] idx);
    case (idx)
      2'd0:    corner_pat = DATA_WIDTH'(32'h00000000);
      2'd1:    corner_pat = DATA_WIDTH'(32'hFFFFFFFF);
      2'd2:    corner_pat = DATA_WIDTH'(32'hAAAAAAAA);
      default: corner_pat = DATA_WIDTH'(32'h55555555);
    endcase
  endfunction

  logic [2:0]                   r_state, w_state_nxt;
  logic [31:0]                  r_lfsr, w_lfsr_nxt;
  logic [1:0]                   r_mode, w_mode_nxt;
  logic [IP_SELECTOR_WIDTH-1:0] r_ip, w_ip_nxt;
  logic [1:0]                   r_corner, w_corner_nxt;
  logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic [WAIT_W-1:0]            r_wait;
  logic                         w_accept, w_in_req, w_expire, w_req_nxt, w_we_nxt;
  logic [ADDR_WIDTH-1:0]        w_ofs_nxt, w_adr_nxt;
  logic [DATA_WIDTH-1:0]        w_dat_nxt;

  logic                  r_busy, r_done, r_timeout, r_cyc, r_we;
  logic [15:0]           r_mismatch;
  logic [DATA_WIDTH-1:0] r_last_rdata, r_payload, r_dat;
  logic [ADDR_WIDTH-1:0] r_adr;

  assign w_in_req = (r_state == S_REQ) || (r_state == S_RB_REQ);
  // An ack on the threshold cycle wins over the timeout.
  assign w_expire = w_in_req && !wbm_ack_i && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next values of the burst context.
  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_mode_nxt   = r_mode;
    w_ip_nxt     = r_ip;
    w_corner_nxt = r_corner;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (mode_selector != 2'd0)) begin
          w_accept     = 1'b1;
          w_state_nxt  = S_REQ;
          w_mode_nxt   = mode_selector;
          w_ip_nxt     = ip_selector;
          w_lfsr_nxt   = (seed == 32'd0) ? LFSR_DEFAULT : seed;
          w_corner_nxt = 2'd0;
          w_cnt_nxt    = '0;
        end
      end
      S_REQ: begin
        if (wbm_ack_i)     w_state_nxt = (r_mode == 2'd3) ? S_RB_REQ : S_NEXT;
        else if (w_expire) w_state_nxt = S_NEXT;
      end
      S_RB_REQ: begin
        if (wbm_ack_i || w_expire) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_lfsr_nxt   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);
        w_corner_nxt = r_corner + 2'd1;
        w_state_nxt  = (w_cnt_nxt < CNT_W'(TRAFFIC_N)) ? S_REQ : S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus request contents for the upcoming cycle, held constant across a request.
  always_comb begin
    w_req_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_RB_REQ);
    w_we_nxt  = 1'b1;
    if (w_state_nxt == S_RB_REQ)  w_we_nxt = 1'b0;
    else if (w_mode_nxt == 2'd1)  w_we_nxt = w_lfsr_nxt[31];
    w_ofs_nxt = ADDR_WIDTH'({w_lfsr_nxt[IP_WINDOW_BITS-1:2], 2'b00});
    w_dat_nxt = w_lfsr_nxt[DATA_WIDTH-1:0];
    if (w_mode_nxt == 2'd2) begin
      w_ofs_nxt = w_corner_nxt[0] ? MAX_OFS : '0;
      w_dat_nxt = corner_pat(w_corner_nxt);
    end
    w_adr_nxt = (ADDR_WIDTH'(w_ip_nxt) << IP_WINDOW_BITS) | w_ofs_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_DEFAULT;
      r_mode       <= 2'd0;
      r_ip         <= '0;
      r_corner     <= 2'd0;
      r_cnt        <= '0;
      r_wait       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_mismatch   <= 16'd0;
      r_last_rdata <= '0;
      r_payload    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_mode    <= w_mode_nxt;
      r_ip      <= w_ip_nxt;
      r_corner  <= w_corner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wait    <= (w_in_req && (w_state_nxt == r_state)) ? r_wait + WAIT_W'(1) : '0;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_cyc     <= w_req_nxt;
      r_we      <= w_req_nxt ? w_we_nxt : 1'b0;
      r_adr     <= w_req_nxt ? w_adr_nxt : '0;
      r_dat     <= w_req_nxt ? w_dat_nxt : '0;
      r_payload <= corner_pat(w_corner_nxt);
      if (w_accept) begin
        r_timeout  <= 1'b0;
        r_mismatch <= 16'd0;
      end else begin
        if (w_expire) r_timeout <= 1'b1;
        if ((r_state == S_RB_REQ) && wbm_ack_i && (wbm_dat_i != r_lfsr[DATA_WIDTH-1:0]) &&
            (r_mismatch != 16'hFFFF))
          r_mismatch <= r_mismatch + 16'd1;
      end
      if (w_in_req && wbm_ack_i && !r_we) r_last_rdata <= wbm_dat_i;
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign timeout             = r_timeout;
  assign mismatch_cnt        = r_mismatch;
  assign last_rdata          = r_last_rdata;
  assign corner_case_payload = r_payload;
  assign wbm_cyc_o           = r_cyc;
  assign wbm_stb_o           = r_cyc;
  assign wbm_we_o            = r_we;
  assign wbm_adr_o           = r_adr;
  assign wbm_dat_o           = r_dat;
  assign wbm_sel_o           = {SEL_W{1'b1}};
  assign wbm_cti_o           = 3'b000;
  assign wbm_bte_o           = 2'b00;

endmodule
